// File: rtl/insertion_sort_p.sv
// insertion_sort_p: in-place insertion sort over a DEPTH-word array.
// Ports: clk/rst/enable, push/pop/clear/sort levels, descend, din/dout,
//        count/full/empty, idle/busy/done/err status.
module insertion_sort_p #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int SIGNED = 0,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             sort,
  input  logic             descend,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             idle,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [AW:0] DCNT = DEPTH[AW:0];

  typedef enum logic [3:0] {
    IDLE, CLEAR, PUSH, POP,
    J_INIT, J_TEST, I_INIT, I_TEST,
    SHIFT, INSERT, J_NEXT, S_DONE
  } state_t;

  state_t state, nxt;

  logic [1:0] push_sr, pop_sr, clr_sr, sort_sr;
  logic       push_f, pop_f, clr_f, sort_f;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] key, ai;
  logic [AW:0]      j;
  // i spans -1..DEPTH-2, so its MSB alone flags -1
  logic [AW:0]      i;
  logic [AW-1:0]    j_a, i_a, ip1_a, cnt_a, top_a;
  logic             desc_q, le, ge, ord;

  assign push_f = (push_sr == 2'b01);
  assign pop_f  = (pop_sr == 2'b01);
  assign clr_f  = (clr_sr == 2'b01);
  assign sort_f = (sort_sr == 2'b01);

  assign full  = (count == DCNT);
  assign empty = (count == '0);
  assign idle  = (state == IDLE);
  assign done  = (state == S_DONE);
  assign busy  = (state inside {J_INIT, J_TEST,
                  I_INIT, I_TEST, SHIFT, INSERT,
                  J_NEXT, S_DONE});

  assign j_a   = j[AW-1:0];
  assign i_a   = i[AW-1:0];
  // wraps -1 to 0 without needing the sign bit
  assign ip1_a = i[AW-1:0] + 1'b1;
  assign cnt_a = count[AW-1:0];
  // when count==DEPTH the low bits are 0, so this gives DEPTH-1
  assign top_a = count[AW-1:0] - 1'b1;
  assign ai    = mem[i_a];

  // Non-strict compare keeps equal keys in push order
  always_comb begin
    le = 1'b0;
    ge = 1'b0;
    if (SIGNED != 0) begin
      le = $signed(ai) <= $signed(key);
      ge = $signed(ai) >= $signed(key);
    end else begin
      le = ai <= key;
      ge = ai >= key;
    end
    ord = desc_q ? ge : le;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (clr_f)       nxt = CLEAR;
        else if (push_f) nxt = PUSH;
        else if (pop_f)  nxt = POP;
        else if (sort_f) nxt = J_INIT;
      end
      CLEAR, PUSH, POP, S_DONE: nxt = IDLE;
      J_INIT: nxt = J_TEST;
      J_TEST: nxt = (j >= count) ? S_DONE : I_INIT;
      I_INIT: nxt = I_TEST;
      I_TEST: nxt = (i[AW] || ord) ? INSERT : SHIFT;
      SHIFT:  nxt = I_TEST;
      INSERT: nxt = J_NEXT;
      J_NEXT: nxt = J_TEST;
      default: nxt = IDLE;
    endcase
    if (busy && clr_f) nxt = CLEAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= IDLE;
    else if (enable) state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_sr <= '0;
      pop_sr  <= '0;
      clr_sr  <= '0;
      sort_sr <= '0;
      dout    <= '0;
      count   <= '0;
      err     <= 1'b0;
      desc_q  <= 1'b0;
      j       <= '0;
      i       <= '0;
      key     <= '0;
    end else if (enable) begin
      push_sr <= {push_sr[0], push};
      pop_sr  <= {pop_sr[0], pop};
      clr_sr  <= {clr_sr[0], clear};
      sort_sr <= {sort_sr[0], sort};
      unique case (state)
        CLEAR: begin
          count <= '0;
          err   <= 1'b0;
        end
        PUSH: begin
          if (full) err <= 1'b1;
          else      count <= count + 1'b1;
        end
        POP: begin
          if (empty) begin
            err <= 1'b1;
          end else begin
            dout  <= mem[top_a];
            count <= count - 1'b1;
          end
        end
        J_INIT: begin
          j      <= (AW+1)'(1);
          desc_q <= descend;
        end
        J_TEST: key <= mem[j_a];
        I_INIT: i <= j - 1'b1;
        SHIFT:  i <= i - 1'b1;
        J_NEXT: j <= j + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enable) begin
      unique case (state)
        PUSH:    if (!full) mem[cnt_a] <= din;
        SHIFT:   mem[ip1_a] <= ai;
        INSERT:  mem[ip1_a] <= key;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_insertion_sort_p.sv
// tb_insertion_sort_p: directed bench for insertion_sort_p.
// Two instances share stimulus: u_s (DEPTH=4, signed), u_u (DEPTH=8).
module tb_insertion_sort_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic push = 1'b0, pop = 1'b0;
  logic clear = 1'b0, sort = 1'b0;
  logic descend = 1'b0;
  logic [15:0] din = '0;

  logic [15:0] dout_s, dout_u;
  logic [2:0]  count_s;
  logic [3:0]  count_u;
  logic full_s, empty_s, idle_s, busy_s, done_s, err_s;
  logic full_u, empty_u, idle_u, busy_u, done_u, err_u;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  insertion_sort_p #(.WIDTH(16), .DEPTH(4), .SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .enable(enable),
    .push(push), .pop(pop), .clear(clear),
    .sort(sort), .descend(descend), .din(din),
    .dout(dout_s), .count(count_s),
    .full(full_s), .empty(empty_s),
    .idle(idle_s), .busy(busy_s),
    .done(done_s), .err(err_s)
  );

  insertion_sort_p #(.WIDTH(16), .DEPTH(8), .SIGNED(0)) u_u (
    .clk(clk), .rst(rst), .enable(enable),
    .push(push), .pop(pop), .clear(clear),
    .sort(sort), .descend(descend), .din(din),
    .dout(dout_u), .count(count_u),
    .full(full_u), .empty(empty_u),
    .idle(idle_u), .busy(busy_u),
    .done(done_u), .err(err_u)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // 0 push, 1 pop, 2 clear
  task automatic pulse(input int c);
    @(negedge clk);
    case (c)
      0: push = 1'b1;
      1: pop = 1'b1;
      default: clear = 1'b1;
    endcase
    repeat (4) @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] d);
    din = d;
    pulse(0);
  endtask

  task automatic rd(input string tag,
                    input logic [15:0] es,
                    input logic [15:0] eu);
    pulse(1);
    chk({tag, "_s"}, dout_s, es);
    chk({tag, "_u"}, dout_u, eu);
  endtask

  // ev: 0 none, 1 enable low 10 cycles, 2 clear, 3 rst
  task automatic run_sort(input logic desc,
                          input int ev, input int at,
                          output int cs, output int cu,
                          output int ds, output int du);
    logic fin;
    fin = 1'b0;
    cs = 0; cu = 0; ds = 0; du = 0;
    @(negedge clk);
    descend = desc;
    sort = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (k == 3) sort = 1'b0;
      case (ev)
        1: enable = !(k >= at && k < at + 10);
        2: clear = (k >= at && k < at + 4);
        3: rst = (k >= at && k < at + 2);
        default: ;
      endcase
      if (busy_s) cs++;
      if (busy_u) cu++;
      if (done_s) ds++;
      if (done_u) du++;
      if (k > at + 12 && idle_s && idle_u) begin
        fin = 1'b1;
        break;
      end
    end
    sort = 1'b0;
    clear = 1'b0;
    rst = 1'b0;
    enable = 1'b1;
    chk("sort_end", 32'(fin), 32'd1);
  endtask

  int cs, cu, ds, du;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt_s", 32'(count_s), 0);
    chk("rst_cnt_u", 32'(count_u), 0);
    chk("rst_dout", 32'({dout_s, dout_u}), 0);
    chk("rst_flags_s",
        {26'd0, err_s, done_s, busy_s, idle_s,
         empty_s, full_s}, 32'b000_110);
    chk("rst_flags_u",
        {26'd0, err_u, done_u, busy_u, idle_u,
         empty_u, full_u}, 32'b000_110);

    // unsigned ascending; u_s overflows on the 5th push
    wr(16'd5); wr(16'd2); wr(16'd9);
    wr(16'd2); wr(16'd1);
    chk("a_cnt_s", 32'(count_s), 4);
    chk("a_cnt_u", 32'(count_u), 5);
    chk("a_full_s", 32'(full_s), 1);
    chk("a_err_s", 32'(err_s), 1);
    chk("a_err_u", 32'(err_u), 0);
    run_sort(1'b0, 0, 0, cs, cu, ds, du);
    chk("a_cyc_s", cs, 24);
    chk("a_cyc_u", cu, 37);
    chk("a_done_s", ds, 1);
    chk("a_done_u", du, 1);
    rd("a_p0", 16'd9, 16'd9);
    rd("a_p1", 16'd5, 16'd5);
    rd("a_p2", 16'd2, 16'd2);
    rd("a_p3", 16'd2, 16'd2);
    rd("a_p4", 16'd2, 16'd1);
    chk("a_end_cnt_u", 32'(count_u), 0);
    chk("a_end_err_u", 32'(err_u), 0);
    chk("a_end_cnt_s", 32'(count_s), 0);
    pulse(2);
    chk("a_clr_err_s", 32'(err_s), 0);

    // descending: signed vs unsigned order differs
    wr(16'hFFFD); wr(16'h0007);
    wr(16'h0000); wr(16'hFFF8);
    run_sort(1'b1, 0, 0, cs, cu, ds, du);
    chk("b_cyc_s", cs, 22);
    chk("b_cyc_u", cu, 22);
    rd("b_p0", 16'hFFF8, 16'h0000);
    rd("b_p1", 16'hFFFD, 16'h0007);
    rd("b_p2", 16'h0000, 16'hFFF8);
    rd("b_p3", 16'h0007, 16'hFFFD);
    chk("b_err", 32'({err_s, err_u}), 0);

    // stability: equal keys must not shift (17 not 19)
    wr(16'd4); wr(16'd4); wr(16'd1);
    run_sort(1'b0, 0, 0, cs, cu, ds, du);
    chk("c_cyc_s", cs, 17);
    chk("c_cyc_u", cu, 17);
    rd("c_p0", 16'd4, 16'd4);
    rd("c_p1", 16'd4, 16'd4);
    rd("c_p2", 16'd1, 16'd1);

    // full / err / clear / pop-empty
    wr(16'd10); wr(16'd20); wr(16'd30); wr(16'd40);
    chk("d_full_s", 32'(full_s), 1);
    chk("d_full_u", 32'(full_u), 0);
    wr(16'd50);
    chk("d_err_s", 32'(err_s), 1);
    chk("d_cnt_s", 32'(count_s), 4);
    chk("d_cnt_u", 32'(count_u), 5);
    pulse(2);
    chk("d_clr_cnt", 32'({count_s, count_u}), 0);
    chk("d_clr_err", 32'({err_s, err_u}), 0);
    chk("d_clr_empty", 32'({empty_s, empty_u}), 3);
    pulse(1);
    chk("d_pe_err", 32'({err_s, err_u}), 3);
    chk("d_pe_dout_s", 32'(dout_s), 1);
    chk("d_pe_dout_u", 32'(dout_u), 1);
    pulse(2);

    // abort by clear mid-sort
    for (int v = 8; v >= 1; v--) wr(16'(v * 10));
    chk("e_cnt_u", 32'(count_u), 8);
    chk("e_full_u", 32'(full_u), 1);
    run_sort(1'b0, 2, 20, cs, cu, ds, du);
    chk("e_done", ds + du, 0);
    chk("e_cnt", 32'({count_s, count_u}), 0);
    chk("e_err", 32'({err_s, err_u}), 0);
    chk("e_busy", 32'({busy_s, busy_u}), 0);
    run_sort(1'b0, 0, 0, cs, cu, ds, du);
    chk("e_empty_cyc", cs, 3);
    chk("e_empty_done", ds + du, 2);

    // enable gating: same result, 10 extra cycles
    wr(16'd6); wr(16'd3); wr(16'd5); wr(16'd1);
    run_sort(1'b0, 0, 0, cs, cu, ds, du);
    chk("f_cyc_ref", cs, 28);
    rd("f_r0", 16'd6, 16'd6);
    rd("f_r1", 16'd5, 16'd5);
    rd("f_r2", 16'd3, 16'd3);
    rd("f_r3", 16'd1, 16'd1);
    wr(16'd6); wr(16'd3); wr(16'd5); wr(16'd1);
    run_sort(1'b0, 1, 8, cs, cu, ds, du);
    chk("f_cyc_s", cs, 38);
    chk("f_cyc_u", cu, 38);
    chk("f_done", ds + du, 2);
    rd("f_g0", 16'd6, 16'd6);
    rd("f_g1", 16'd5, 16'd5);
    rd("f_g2", 16'd3, 16'd3);
    rd("f_g3", 16'd1, 16'd1);

    // reset mid-sort
    wr(16'd6); wr(16'd3); wr(16'd5); wr(16'd1);
    run_sort(1'b0, 3, 8, cs, cu, ds, du);
    chk("g_done", ds + du, 0);
    chk("g_cnt", 32'({count_s, count_u}), 0);
    chk("g_dout", 32'({dout_s, dout_u}), 0);
    chk("g_flags",
        {26'd0, err_s, err_u, busy_s, busy_u,
         idle_s, idle_u}, 32'b000011);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
